// File: rtl/two_port_ram_bridge_if.sv
// rtl/two_port_ram_bridge_if.sv - kernel memory channels and two-port RAM signals for the bridge
interface two_port_ram_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_addr_valid;
  logic                  ld_addr_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_data_valid;
  logic                  ld_data_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_valid;
  logic                  st_ready;
  logic                  end_valid;
  logic                  end_ready;
  logic                  ce0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] address0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  ce1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] address1;
  logic [DATA_WIDTH-1:0] din1;
  logic                  done;
  logic [31:0]           trans_count;

  modport slave (
    input  ld_addr, ld_addr_valid, ld_data_ready,
    input  st_addr, st_data, st_valid, end_valid, dout0,
    output ld_addr_ready, ld_data, ld_data_valid, st_ready, end_ready,
    output ce0, we0, address0, ce1, we1, address1, din1, done, trans_count
  );

  modport master (
    output ld_addr, ld_addr_valid, ld_data_ready,
    output st_addr, st_data, st_valid, end_valid, dout0,
    input  ld_addr_ready, ld_data, ld_data_valid, st_ready, end_ready,
    input  ce0, we0, address0, ce1, we1, address1, din1, done, trans_count
  );
endinterface

// File: rtl/two_port_ram_bridge.sv
// rtl/two_port_ram_bridge.sv - handshake-to-RAM bridge with 2-entry load return buffer and done pulse
module two_port_ram_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  two_port_ram_bridge_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [31:0]           trans_count_q;

  logic ld_fire;
  logic st_fire;
  logic bypass;
  logic push;
  logic pop;

  // Issue gating looks only at occupancy, so ld_data_ready never reaches ld_addr_ready.
  always_comb begin
    state_next        = state;
    bus.ld_addr_ready = 1'b0;
    bus.st_ready      = 1'b0;
    bus.done          = 1'b0;
    bus.end_ready     = 1'b0;
    ld_fire           = 1'b0;
    st_fire           = 1'b0;
    bypass            = 1'b0;
    push              = 1'b0;
    pop               = 1'b0;
    bus.ld_data_valid = 1'b0;
    bus.ld_data       = buf_mem[rd_ptr];

    if (rst) begin
      bus.ld_addr_ready = (state == RUN) &&
                          (({1'b0, buf_count} + {2'b00, inflight}) < 3'd2);
      bus.st_ready      = (state == RUN);
      bus.done          = (state == DONE);
      bus.end_ready     = (state == DONE);
      ld_fire           = bus.ld_addr_valid && bus.ld_addr_ready;
      st_fire           = bus.st_valid && bus.st_ready;
      bypass            = inflight && (buf_count == 2'd0);
      bus.ld_data_valid = bypass || (buf_count != 2'd0);
      if (bypass) begin
        bus.ld_data = bus.dout0;
      end
      push = inflight && !(bypass && bus.ld_data_ready);
      pop  = (buf_count != 2'd0) && bus.ld_data_ready;
    end

    case (state)
      RUN:     if (bus.end_valid) state_next = DRAIN;
      DRAIN:   if (!inflight && (buf_count == 2'd0)) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign bus.ce0         = ld_fire;
  assign bus.we0         = 1'b0;
  assign bus.address0    = bus.ld_addr;
  assign bus.ce1         = st_fire;
  assign bus.we1         = st_fire;
  assign bus.address1    = bus.st_addr;
  assign bus.din1        = bus.st_data;
  assign bus.trans_count = trans_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      inflight      <= 1'b0;
      buf_count     <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      trans_count_q <= 32'd0;
    end else begin
      state    <= state_next;
      inflight <= ld_fire;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
      if (state == DONE) begin
        trans_count_q <= trans_count_q + 32'd1;
      end
    end
  end

  // RAM read data is captured the cycle after issue unless the bypass hands it straight out.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr] <= bus.dout0;
    end
  end

endmodule

// File: tb/tb_two_port_ram_bridge.sv
// tb/tb_two_port_ram_bridge.sv - scoreboard bench for two_port_ram_bridge with write-first RAM model
module tb_two_port_ram_bridge;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [DW-1:0] ram_mem [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] sb_exp;

  two_port_ram_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  two_port_ram_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first two-port RAM, one-cycle read latency, dout0 holds while ce0 is low.
  always @(posedge clk) begin
    if (bus.ce1 && bus.we1) ram_mem[bus.address1] <= bus.din1;
    if (bus.ce0) begin
      if (bus.ce1 && bus.we1 && (bus.address1 == bus.address0)) bus.dout0 <= bus.din1;
      else bus.dout0 <= ram_mem[bus.address0];
    end
  end

  // Scoreboard: expected value pushed on load accept, compared on result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (bus.ld_data_valid && bus.ld_data_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got ld_data=%h with no outstanding load", bus.ld_data);
        end else begin
          sb_exp = sb_q.pop_front();
          if (bus.ld_data !== sb_exp) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", bus.ld_data, sb_exp);
          end
        end
      end
      if (bus.st_valid && bus.st_ready) ref_mem[bus.st_addr] = bus.st_data;
      if (bus.ld_addr_valid && bus.ld_addr_ready) sb_q.push_back(ref_mem[bus.ld_addr]);
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    bus.ld_addr_valid = 1'b1;
    bus.ld_addr = '0;
    bus.st_valid = 1'b1;
    bus.st_addr = 10'd100;
    bus.st_data = 32'h1;
    bus.end_valid = 1'b0;
    bus.ld_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ce0, bus.ce1, bus.done, bus.end_ready, bus.ld_data_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: ce0,ce1,done,end_ready,ld_data_valid=%b expected 00000",
               {bus.ce0, bus.ce1, bus.done, bus.end_ready, bus.ld_data_valid});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ld_addr_valid = 1'b0;
    bus.st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_addr_ready, bus.st_ready, bus.we0, bus.ld_data_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ready: ld_addr_ready,st_ready,we0,ld_data_valid=%b expected 1100",
               {bus.ld_addr_ready, bus.st_ready, bus.we0, bus.ld_data_valid});
    end
    checks++;
    if (bus.trans_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: trans_count=%0d expected 0", bus.trans_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bus.ld_data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_addr = AW'(i);
      bus.ld_addr_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ld_addr_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ld_addr_ready=%b expected 1", i, bus.ld_addr_ready);
      end
      if (i > 0) begin
        checks++;
        if (bus.ld_data_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_valid[%0d]: ld_data_valid=%b expected 1", i, bus.ld_data_valid);
        end
      end
      @(posedge clk); #1;
    end
    bus.ld_addr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ld_data_valid !== 1'b1 || bus.ld_data !== 32'h13) begin
      errors++;
      $display("FAIL b2b_last: valid=%b data=%h expected 1 00000013", bus.ld_data_valid, bus.ld_data);
    end
    @(negedge clk);
    checks++;
    if (bus.ld_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ld_data_valid=%b expected 0", bus.ld_data_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit accepted;
    bus.ld_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_addr = AW'(i);
      bus.ld_addr_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ld_addr_ready !== (i < 2)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: ld_addr_ready=%b expected %b", i, bus.ld_addr_ready, i < 2);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.ld_addr_ready !== 1'b0 || bus.ld_data_valid !== 1'b1 || bus.ld_data !== 32'h10) begin
      errors++;
      $display("FAIL bp_stall: ready=%b valid=%b data=%h expected 0 1 00000010",
               bus.ld_addr_ready, bus.ld_data_valid, bus.ld_data);
    end
    @(posedge clk); #1;
    bus.ld_data_ready = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.ld_addr_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL bp_accept2: ld_addr_ready never rose, expected address 2 accepted");
    end
    @(posedge clk); #1;
    bus.ld_addr_valid = 1'b0;
    for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d results outstanding expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_forward();
    bus.ld_data_ready = 1'b1;
    bus.st_addr = 10'd5;
    bus.st_data = 32'hDEADBEEF;
    bus.st_valid = 1'b1;
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    bus.ld_addr = 10'd5;
    bus.ld_addr_valid = 1'b1;
    @(posedge clk); #1;
    bus.ld_addr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ld_data_valid !== 1'b1 || bus.ld_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_next: valid=%b data=%h expected 1 deadbeef", bus.ld_data_valid, bus.ld_data);
    end
    @(posedge clk); #1;
    bus.st_addr = 10'd6;
    bus.st_data = 32'hCAFE0001;
    bus.st_valid = 1'b1;
    bus.ld_addr = 10'd6;
    bus.ld_addr_valid = 1'b1;
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    bus.ld_addr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ld_data_valid !== 1'b1 || bus.ld_data !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL fwd_same: valid=%b data=%h expected 1 cafe0001", bus.ld_data_valid, bus.ld_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_end_pending();
    bit seen;
    bus.ld_data_ready = 1'b0;
    bus.ld_addr = 10'd3;
    bus.ld_addr_valid = 1'b1;
    @(posedge clk); #1;
    bus.ld_addr_valid = 1'b0;
    bus.end_valid = 1'b1;
    @(posedge clk); #1;
    bus.end_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if ({bus.st_ready, bus.done, bus.end_ready, bus.ld_data_valid} !== 4'b0001) begin
        errors++;
        $display("FAIL endp_hold[%0d]: st_ready,done,end_ready,ld_data_valid=%b expected 0001",
                 n, {bus.st_ready, bus.done, bus.end_ready, bus.ld_data_valid});
      end
      @(posedge clk); #1;
    end
    bus.ld_data_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL endp_early: done=%b expected 0 while result pending", bus.done);
    end
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || bus.end_ready !== 1'b1 || bus.trans_count !== 32'd0) begin
      errors++;
      $display("FAIL endp_done: seen=%b end_ready=%b trans_count=%0d expected 1 1 0",
               seen, bus.end_ready, bus.trans_count);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.trans_count !== 32'd1) begin
      errors++;
      $display("FAIL endp_after: done=%b trans_count=%0d expected 0 1", bus.done, bus.trans_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_end_idle();
    bus.end_valid = 1'b1;
    bus.st_addr = 10'd9;
    bus.st_data = 32'h55AA0009;
    bus.st_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.st_ready !== 1'b1 || bus.ce1 !== 1'b1) begin
      errors++;
      $display("FAIL endi_store: st_ready=%b ce1=%b expected 1 1", bus.st_ready, bus.ce1);
    end
    @(posedge clk); #1;
    bus.end_valid = 1'b0;
    bus.st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL endi_drain: done=%b expected 0", bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.end_ready !== 1'b1) begin
      errors++;
      $display("FAIL endi_done: done=%b end_ready=%b expected 1 1", bus.done, bus.end_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.trans_count !== 32'd2) begin
      errors++;
      $display("FAIL endi_after: done=%b trans_count=%0d expected 0 2", bus.done, bus.trans_count);
    end
    @(posedge clk); #1;
    bus.ld_addr = 10'd9;
    bus.ld_addr_valid = 1'b1;
    @(posedge clk); #1;
    bus.ld_addr_valid = 1'b0;
    for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL endi_load: %0d results outstanding expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bus.ld_data_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_addr = AW'(i);
      bus.ld_addr_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.ld_addr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.ld_addr_ready !== 1'b0 || bus.ld_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_full: ld_addr_ready=%b ld_data_valid=%b expected 0 1",
               bus.ld_addr_ready, bus.ld_data_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ld_addr_valid = 1'b1;
    bus.st_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ce0, bus.ce1, bus.ld_data_valid, bus.done} !== 4'b0) begin
      errors++;
      $display("FAIL mrst_during: ce0,ce1,ld_data_valid,done=%b expected 0000",
               {bus.ce0, bus.ce1, bus.ld_data_valid, bus.done});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ld_addr_valid = 1'b0;
    bus.st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_data_valid, bus.ld_addr_ready, bus.done} !== 3'b010 || bus.trans_count !== 32'd0) begin
      errors++;
      $display("FAIL mrst_after: valid,ready,done=%b trans_count=%0d expected 010 0",
               {bus.ld_data_valid, bus.ld_addr_ready, bus.done}, bus.trans_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = 32'h10 + 32'(i);
      ref_mem[i] = 32'h10 + 32'(i);
    end
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_store_forward();
    test_end_pending();
    test_end_idle();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
